ddr5_cmd_sequencer: RTL and testbench

Converts one accepted memory request at a time into a legal DDR5 command sequence under open-page policy. Supported commands are ACT0/ACT1, RD0/RD1, WR0/WR1 and PRE, with per-bank open-row tracking and tRCD/tRP/tRAS/CAS-latency timing enforcement. The block sits between the request queue (upstream) and the command logger/output stage (downstream), which records each issued command cycle by cycle.

---
 rtl/ddr5_cmd_sequencer_if.sv | 49 ++++
 rtl/ddr5_cmd_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_ddr5_cmd_sequencer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr5_cmd_sequencer_if.sv
// ddr5_cmd_sequencer request/command bundle.
// Master = request queue side, slave = sequencer.
interface ddr5_cmd_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [33:0] req_addr;
  logic        cmd_valid;
  logic [2:0]  cmd;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        done_valid;
  logic [1:0]  done_op;

  modport master (
    output req_valid,
    output req_op,
    output req_addr,
    input  req_ready,
    input  cmd_valid,
    input  cmd,
    input  cmd_channel,
    input  cmd_bg,
    input  cmd_bank,
    input  cmd_row,
    input  cmd_col,
    input  done_valid,
    input  done_op
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_addr,
    output req_ready,
    output cmd_valid,
    output cmd,
    output cmd_channel,
    output cmd_bg,
    output cmd_bank,
    output cmd_row,
    output cmd_col,
    output done_valid,
    output done_op
  );
endinterface

// File: rtl/ddr5_cmd_sequencer.sv
// DDR5 open-page command sequencer: one request at a time,
// per-bank open-row table, tRCD/tRP/tRAS/CL/CWL enforcement.
module ddr5_cmd_sequencer #(
  parameter int T_RCD   = 39,
  parameter int T_RP    = 39,
  parameter int T_RAS   = 76,
  parameter int T_CL    = 40,
  parameter int T_CWL   = 38,
  parameter int T_BURST = 8
) (
  input logic clock,
  input logic reset_n,
  ddr5_cmd_sequencer_if.slave bus
);

  localparam int CW = 16;
  localparam logic [CW-1:0] L_RCD = CW'(T_RCD - 1);
  localparam logic [CW-1:0] L_RP  = CW'(T_RP - 1);
  localparam logic [CW-1:0] L_RAS = CW'(T_RAS - 1);
  localparam logic [CW-1:0] L_RD  = CW'(T_CL + T_BURST - 1);
  localparam logic [CW-1:0] L_WR  = CW'(T_CWL + T_BURST - 1);

  localparam logic [2:0] C_ACT0 = 3'd1;
  localparam logic [2:0] C_ACT1 = 3'd2;
  localparam logic [2:0] C_RD0  = 3'd3;
  localparam logic [2:0] C_RD1  = 3'd4;
  localparam logic [2:0] C_WR0  = 3'd5;
  localparam logic [2:0] C_WR1  = 3'd6;
  localparam logic [2:0] C_PRE  = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_PRE,
    S_WAIT_RP,
    S_ACT0,
    S_ACT1,
    S_WAIT_RCD,
    S_CAS0,
    S_CAS1,
    S_WAIT_DATA
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [1:0]  r_op;
  logic [15:0] r_row;
  logic [5:0]  r_colh;
  logic [3:0]  r_coll;
  logic [1:0]  r_bank;
  logic [2:0]  r_bg;
  logic        r_ch;

  logic [CW-1:0] r_rcd_cnt;
  logic [CW-1:0] r_rp_cnt;
  logic [CW-1:0] r_ras_cnt;
  logic [CW-1:0] r_dat_cnt;

  logic [31:0] r_tbl_vld;
  logic [15:0] r_tbl_row [32];

  logic       w_accept;
  logic       w_ready;
  logic       w_cmd_valid;
  logic [2:0] w_cmd;
  logic       w_done;
  logic       w_ld_rp;
  logic       w_ld_act;
  logic       w_ld_dat;
  logic       w_tbl_set;
  logic       w_tbl_clr;
  logic [4:0] w_idx;
  logic       w_vld;
  logic       w_hit;
  logic       w_wr;

  assign w_idx = {r_bg, r_bank};
  assign w_vld = r_tbl_vld[w_idx];
  assign w_hit = w_vld && (r_tbl_row[w_idx] == r_row);
  assign w_wr  = (r_op == 2'd1);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Next state, issued command and datapath strobes.
  always_comb begin
    w_nxt       = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_cmd_valid = 1'b0;
    w_cmd       = 3'd0;
    w_done      = 1'b0;
    w_ld_rp     = 1'b0;
    w_ld_act    = 1'b0;
    w_ld_dat    = 1'b0;
    w_tbl_set   = 1'b0;
    w_tbl_clr   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_nxt    = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_hit)       w_nxt = S_CAS0;
        else if (!w_vld) w_nxt = S_ACT0;
        else             w_nxt = S_PRE;
      end
      S_PRE: begin
        if (r_ras_cnt == '0) begin
          w_cmd_valid = 1'b1;
          w_cmd       = C_PRE;
          w_tbl_clr   = 1'b1;
          w_ld_rp     = 1'b1;
          w_nxt       = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        // leave one cycle early so ACT0 lands as rp_cnt hits 0
        if (r_rp_cnt <= CW'(1)) w_nxt = S_ACT0;
      end
      S_ACT0: begin
        w_cmd_valid = 1'b1;
        w_cmd       = C_ACT0;
        w_ld_act    = 1'b1;
        w_tbl_set   = 1'b1;
        w_nxt       = S_ACT1;
      end
      S_ACT1: begin
        w_cmd_valid = 1'b1;
        w_cmd       = C_ACT1;
        w_nxt       = S_WAIT_RCD;
      end
      S_WAIT_RCD: begin
        if (r_rcd_cnt <= CW'(1)) w_nxt = S_CAS0;
      end
      S_CAS0: begin
        w_cmd_valid = 1'b1;
        w_cmd       = w_wr ? C_WR0 : C_RD0;
        w_ld_dat    = 1'b1;
        w_nxt       = S_CAS1;
      end
      S_CAS1: begin
        w_cmd_valid = 1'b1;
        w_cmd       = w_wr ? C_WR1 : C_RD1;
        w_nxt       = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (r_dat_cnt == '0) begin
          w_done = 1'b1;
          w_nxt  = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // Latch op and mapped address fields on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op   <= '0;
      r_row  <= '0;
      r_colh <= '0;
      r_coll <= '0;
      r_bank <= '0;
      r_bg   <= '0;
      r_ch   <= 1'b0;
    end else if (w_accept) begin
      r_op   <= bus.req_op;
      r_row  <= bus.req_addr[33:18];
      r_colh <= bus.req_addr[17:12];
      r_bank <= bus.req_addr[11:10];
      r_bg   <= bus.req_addr[9:7];
      r_ch   <= bus.req_addr[6];
      r_coll <= bus.req_addr[5:2];
    end
  end

  // Saturating timing down-counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rcd_cnt <= '0;
      r_rp_cnt  <= '0;
      r_ras_cnt <= '0;
      r_dat_cnt <= '0;
    end else begin
      if (w_ld_act)             r_rcd_cnt <= L_RCD;
      else if (r_rcd_cnt != '0) r_rcd_cnt <= r_rcd_cnt - 1'b1;
      if (w_ld_rp)              r_rp_cnt  <= L_RP;
      else if (r_rp_cnt != '0)  r_rp_cnt  <= r_rp_cnt - 1'b1;
      if (w_ld_act)             r_ras_cnt <= L_RAS;
      else if (r_ras_cnt != '0) r_ras_cnt <= r_ras_cnt - 1'b1;
      if (w_ld_dat)             r_dat_cnt <= w_wr ? L_WR : L_RD;
      else if (r_dat_cnt != '0) r_dat_cnt <= r_dat_cnt - 1'b1;
    end
  end

  // Open-row table, shared by both channels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_tbl_vld <= '0;
      for (int i = 0; i < 32; i++) r_tbl_row[i] <= '0;
    end else if (w_tbl_set) begin
      r_tbl_vld[w_idx] <= 1'b1;
      r_tbl_row[w_idx] <= r_row;
    end else if (w_tbl_clr) begin
      r_tbl_vld[w_idx] <= 1'b0;
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.cmd_valid   = w_cmd_valid;
  assign bus.cmd         = w_cmd;
  assign bus.cmd_channel = r_ch;
  assign bus.cmd_bg      = r_bg;
  assign bus.cmd_bank    = r_bank;
  assign bus.cmd_row     = r_row;
  assign bus.cmd_col     = {r_colh, r_coll};
  assign bus.done_valid  = w_done;
  assign bus.done_op     = w_done ? r_op : 2'd0;

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Directed bench for ddr5_cmd_sequencer: default timing
// instance plus a T_RAS=200 instance sharing one driver.
module tb_ddr5_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sel = 1'b0;
  logic t_valid = 1'b0;
  logic [1:0] t_op = '0;
  logic [33:0] t_addr = '0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ddr5_cmd_sequencer_if ifa ();
  ddr5_cmd_sequencer_if ifb ();

  assign ifa.req_valid = t_valid & ~sel;
  assign ifa.req_op    = t_op;
  assign ifa.req_addr  = t_addr;
  assign ifb.req_valid = t_valid & sel;
  assign ifb.req_op    = t_op;
  assign ifb.req_addr  = t_addr;

  ddr5_cmd_sequencer u_dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifa)
  );

  ddr5_cmd_sequencer #(.T_RAS(200)) u_ras (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (ifb)
  );

  logic        m_ready, m_cmd_valid, m_ch, m_done;
  logic [2:0]  m_cmd, m_bg;
  logic [1:0]  m_bank, m_done_op;
  logic [15:0] m_row;
  logic [9:0]  m_col;

  assign m_ready     = sel ? ifb.req_ready   : ifa.req_ready;
  assign m_cmd_valid = sel ? ifb.cmd_valid   : ifa.cmd_valid;
  assign m_cmd       = sel ? ifb.cmd         : ifa.cmd;
  assign m_ch        = sel ? ifb.cmd_channel : ifa.cmd_channel;
  assign m_bg        = sel ? ifb.cmd_bg      : ifa.cmd_bg;
  assign m_bank      = sel ? ifb.cmd_bank    : ifa.cmd_bank;
  assign m_row       = sel ? ifb.cmd_row     : ifa.cmd_row;
  assign m_col       = sel ? ifb.cmd_col     : ifa.cmd_col;
  assign m_done      = sel ? ifb.done_valid  : ifa.done_valid;
  assign m_done_op   = sel ? ifb.done_op     : ifa.done_op;

  // Cycle offsets are relative to the accept cycle; -1 = absent.
  typedef struct {
    logic [1:0]  op;
    logic [33:0] addr;
    int          pre;
    int          act;
    int          cas;
    int          done;
    logic [15:0] row;
    logic [9:0]  col;
    logic [2:0]  bg;
    logic [1:0]  bank;
    logic        ch;
  } vec_t;

  vec_t va [9];
  vec_t vb [3];
  vec_t vr;

  function automatic vec_t mk(
    input logic [1:0] op, input logic [33:0] addr,
    input int pre, input int act, input int cas,
    input int done, input logic [15:0] row,
    input logic [9:0] col, input logic [2:0] bg,
    input logic [1:0] bank, input logic ch);
    vec_t v;
    v.op = op; v.addr = addr; v.pre = pre;
    v.act = act; v.cas = cas; v.done = done;
    v.row = row; v.col = col; v.bg = bg;
    v.bank = bank; v.ch = ch;
    return v;
  endfunction

  task automatic chk(input string nm, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after done.
  task automatic run_vec(input vec_t v, input string tag);
    int w, pre_c, a0, a1, c0, c1, dn, n, bad_f, bad_i;
    int code0, code1, exp_n, exp_code;
    logic [15:0] row_c;
    logic [9:0]  col_c;
    logic [1:0]  dop;
    logic        rdy_d;
    pre_c = -1; a0 = -1; a1 = -1; c0 = -1; c1 = -1;
    dn = -1; n = 0; bad_f = 0; bad_i = 0;
    code0 = 0; code1 = 0; row_c = '0; col_c = '0;
    dop = '0; rdy_d = 1'b1;
    t_op = v.op; t_addr = v.addr; t_valid = 1'b1;
    #1;
    w = 0;
    while (!m_ready && w < 300) begin
      @(negedge clk); #1; w++;
    end
    @(posedge clk);
    #1 t_valid = 1'b0;
    for (int rel = 1; rel <= 400; rel++) begin
      @(negedge clk);
      if ({m_ch, m_bg, m_bank} != {v.ch, v.bg, v.bank})
        bad_f++;
      if (m_cmd_valid) begin
        n++;
        case (m_cmd)
          3'd7: pre_c = rel;
          3'd1: begin a0 = rel; row_c = m_row; end
          3'd2: a1 = rel;
          3'd3, 3'd5: begin
            c0 = rel; code0 = int'(m_cmd); col_c = m_col;
          end
          3'd4, 3'd6: begin c1 = rel; code1 = int'(m_cmd); end
          default: bad_i++;
        endcase
      end else if (m_cmd != 3'd0) bad_i++;
      if (m_done) begin
        dn = rel; dop = m_done_op; rdy_d = m_ready;
        break;
      end
    end
    @(negedge clk);
    exp_n = 2 + (v.pre >= 0 ? 1 : 0) + (v.act >= 0 ? 2 : 0);
    exp_code = (v.op == 2'd1) ? 5 : 3;
    chk({tag, "_pre"}, pre_c, v.pre);
    chk({tag, "_act0"}, a0, v.act);
    chk({tag, "_act1"}, a1, v.act < 0 ? -1 : v.act + 1);
    chk({tag, "_cas0"}, c0, v.cas);
    chk({tag, "_cas1"}, c1, v.cas + 1);
    chk({tag, "_done"}, dn, v.done);
    chk({tag, "_ncmd"}, n, exp_n);
    chk({tag, "_code0"}, code0, exp_code);
    chk({tag, "_code1"}, code1, exp_code + 1);
    chk({tag, "_row"}, int'(row_c),
        v.act >= 0 ? int'(v.row) : 0);
    chk({tag, "_col"}, int'(col_c), int'(v.col));
    chk({tag, "_fields"}, bad_f, 0);
    chk({tag, "_idlecmd"}, bad_i, 0);
    chk({tag, "_done_op"}, int'(dop), int'(v.op));
    chk({tag, "_rdy_done"}, int'(rdy_d), 0);
    chk({tag, "_rdy_after"}, int'(m_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0] = mk(2'd0, 34'h0,         -1,  2, 41,  89,
               16'h0000, 10'h000, 3'd0, 2'd0, 1'b0);
    va[1] = mk(2'd0, 34'h1000,      -1, -1,  2,  50,
               16'h0000, 10'h010, 3'd0, 2'd0, 1'b0);
    va[2] = mk(2'd0, 34'h40000,      2, 41, 80, 128,
               16'h0001, 10'h000, 3'd0, 2'd0, 1'b0);
    va[3] = mk(2'd0, 34'h40000,     -1, -1,  2,  50,
               16'h0001, 10'h000, 3'd0, 2'd0, 1'b0);
    va[4] = mk(2'd1, 34'hC80,       -1,  2, 41,  87,
               16'h0000, 10'h000, 3'd1, 2'd3, 1'b0);
    va[5] = mk(2'd2, 34'h0,          2, 41, 80, 128,
               16'h0000, 10'h000, 3'd0, 2'd0, 1'b0);
    va[6] = mk(2'd1, 34'h47,        -1, -1,  2,  48,
               16'h0000, 10'h001, 3'd0, 2'd0, 1'b1);
    va[7] = mk(2'd0, 34'h3FFFC0000,  2, 41, 80, 128,
               16'hFFFF, 10'h000, 3'd0, 2'd0, 1'b0);
    va[8] = mk(2'd0, 34'h3FFBC,     -1,  2, 41,  89,
               16'h0000, 10'h3FF, 3'd7, 2'd3, 1'b0);
    vb[0] = mk(2'd0, 34'h0,         -1,  2, 41,  89,
               16'h0000, 10'h000, 3'd0, 2'd0, 1'b0);
    vb[1] = mk(2'd0, 34'h1000,      -1, -1,  2,  50,
               16'h0000, 10'h010, 3'd0, 2'd0, 1'b0);
    vb[2] = mk(2'd0, 34'h40000,     61, 100, 139, 187,
               16'h0001, 10'h000, 3'd0, 2'd0, 1'b0);
    vr    = mk(2'd0, 34'h100,       -1,  2, 41,  89,
               16'h0000, 10'h000, 3'd2, 2'd0, 1'b0);

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(m_ready), 1);
    chk("rst_cmd_valid", int'(m_cmd_valid), 0);
    chk("rst_cmd", int'(m_cmd), 0);
    chk("rst_row", int'(m_row), 0);
    chk("rst_col", int'(m_col), 0);
    chk("rst_chbgbk", int'({m_ch, m_bg, m_bank}), 0);
    chk("rst_done", int'(m_done), 0);
    chk("rst_done_op", int'(m_done_op), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_vec(va[i], $sformatf("va%0d", i));

    sel = 1'b1;
    for (int i = 0; i < 3; i++)
      run_vec(vb[i], $sformatf("ras%0d", i));
    sel = 1'b0;

    // Abort a request while it sits in WAIT_RCD.
    t_op = 2'd0; t_addr = 34'h100; t_valid = 1'b1;
    @(posedge clk);
    #1 t_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mr_in_wait", int'(m_cmd_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_ready", int'(m_ready), 1);
    chk("mr_cmd_valid", int'(m_cmd_valid), 0);
    chk("mr_cmd", int'(m_cmd), 0);
    chk("mr_row", int'(m_row), 0);
    chk("mr_col", int'(m_col), 0);
    chk("mr_chbgbk", int'({m_ch, m_bg, m_bank}), 0);
    chk("mr_done", int'(m_done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vr, "mr_after");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
